jtag_driver: RTL and testbench
==============================

# jtag_driver

JTAG master that drives `tms`/`tdi` into a TAP controller and samples `tdo` back. It executes one command at a time: a TAP reset, an instruction-register scan, a data-register scan, or a run of idle cycles. It keeps a cycle-exact copy of the target TAP's state, using the team's standard 4-bit TAP encoding. It sits between a host/debug command source and any TAP on the same clock, and it always parks the TAP in RUN_TEST_IDLE between commands.

## Interface
- `MAX_LEN`, default 32: maximum scan length in bits, and the width of `cmd_data`/`rsp_data`.
- `CLK` input, 1: the single clock. The driver and the TAP both advance on the rising edge.
- `RESET_N` input, 1: asynchronous, active-low reset.
- `cmd_valid` input, 1: command present.
- `cmd_ready` output, 1: driver can accept a command.
- `cmd_op` input, 2: command select.
  - 0 = RESET
  - 1 = IR_SCAN
  - 2 = DR_SCAN
  - 3 = IDLE
- `cmd_len` input, 6: bit count for a scan, or cycle count for IDLE.
- `cmd_data` input, MAX_LEN: TDI bits, shifted LSB first.
- `rsp_valid` output, 1: one-cycle pulse marking command completion.
- `rsp_data` output, MAX_LEN: captured TDO bits, LSB = first bit shifted; bits at index ≥ len are 0.
- `tms` output, 1: registered TMS.
- `tdi` output, 1: registered TDI.
- `tdo` input, 1: TDO from the target, valid while the TAP is in SHIFT_DR or SHIFT_IR.
- `state` output, 4: tracked TAP state. Encodings: TLR=15, RTI=12, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PA_DR=3, EX2_DR=0, UPD_DR=5, SEL_IR=4, CAP_IR=14, SH_IR=10, EX1_IR=9, PA_IR=11, EX2_IR=8, UPD_IR=13.

## Operation
- **State tracking**
  - `state` is updated at every edge as next = TAP transition(state, tms), using the registered `tms`.
  - This makes `state` equal to the CS of a TAP that receives `tms` on the same `CLK`.
- **Reset values**
  - `state` = TLR, `tms` = 1, `tdi` = 0, `cmd_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0.
- **Boot sequence**
  - After RESET_N deasserts, the driver drives `tms` = 0 for one edge: TLR → RTI.
  - `cmd_ready` is 1 whenever `state` = RTI and no command is active.
- **Command acceptance**
  - A command is accepted on an edge where `cmd_valid` & `cmd_ready`.
  - `cmd_op`, `cmd_len` and `cmd_data` are latched on that edge.
  - `cmd_ready` drops in the following cycle.
- **Length normalisation**
  - `cmd_len` = 0 is treated as 1.
  - `cmd_len` > MAX_LEN is clamped to MAX_LEN.
  - N is the normalised length.
- **TMS sequences**, applied on successive edges after the acceptance edge:
  - RESET: 1,1,1,1,1,0 (reaches TLR from any state, then RTI). `rsp_data` = 0.
  - DR_SCAN:
    - 1, 0, 0 (RTI → SEL_DR → CAP_DR → SH_DR).
    - N shift edges with `tms` = 0, except `tms` = 1 on the last one (→ EX1_DR).
    - 1, 0 (UPD_DR → RTI).
  - IR_SCAN: 1,1,0,0 (→ SH_IR), then N shift edges exactly as DR_SCAN, then 1,0.
  - IDLE: N edges with `tms` = 0, staying in RTI. `rsp_data` = 0.
- **Shifting**
  - During the i-th shift cycle (`state` = SH_xR), `tdi` = `cmd_data[i]`.
  - `tdo` is sampled into `rsp_data[i]` on the edge that ends that cycle.
  - `tdi` = 0 outside shift cycles.
- **Completion**
  - In the first cycle where `state` has returned to RTI, `rsp_valid` = 1 for exactly one cycle.
  - `rsp_data` holds its value until the next completion.
  - `cmd_ready` = 1 in that same cycle, so back-to-back commands are allowed.
- **Reset mid-command**
  - Asserting RESET_N low immediately forces all reset values.
  - The active command is abandoned and no `rsp_valid` is generated for it.
- **Input stability**: `cmd_valid` asserted while `cmd_ready` = 0 is ignored. The inputs need not be held stable.

## Timing
- **Edge numbering**: E0 = acceptance edge. The `tms` value for the first transition is registered at E0.
- **Edges until `state` = RTI**:
  - DR_SCAN: E(N+5).
  - IR_SCAN: E(N+6).
  - RESET: E6.
  - IDLE: EN.
- `rsp_valid` is high in the cycle after that edge.
- **Command-to-command spacing**: accept-to-accept minimum is N+6 cycles for DR_SCAN and N+7 for IR_SCAN.
- **Throughput**: one TAP transition per `CLK`. No combinational path from `tdo` to any output.

## Test plan
- **Boot**: release RESET_N.
  - `state` = 15 in the first cycle and 12 in the next.
  - `cmd_ready` rises the cycle `state` = 12.
- **DR_SCAN, N=8, `cmd_data`=0xA5**, with the TAP model echoing a shift register preloaded with 0x3C.
  - `state` sequence: 7, 6, 2×8, 1, 5, 12.
  - `tdi` sequence: 1,0,1,0,0,1,0,1.
  - `rsp_data` = 0x3C; `rsp_valid` 13 cycles after accept.
- **IR_SCAN, N=4, data 0x9**:
  - `state` sequence: 7, 4, 14, 10×4, 9, 13, 12.
  - `tms` on the last shift edge = 1.
  - Completion at E10.
- **RESET with the TAP parked in PA_DR**:
  - Five `tms`=1 edges bring `state` to 15, then 12.
  - `rsp_data` = 0.
- **Boundaries**:
  - `cmd_len`=0 DR_SCAN shifts 1 bit and completes at E6.
  - `cmd_len`=40 shifts 32 bits and completes at E37.
  - IDLE `cmd_len`=3 completes at E3 with `state` = 12 throughout.
- **Back-to-back and mid-command reset**:
  - Two DR_SCANs with `cmd_valid` held high are accepted in the `rsp_valid` cycle of the first.
  - RESET_N pulsed low mid-shift gives `state` = 15, `cmd_ready` = 0, and no `rsp_valid`.

Source files
------------

// File: rtl/jtag_driver.sv
`default_nettype none
// ============================================================================
// Module   : jtag_driver
// Purpose  : JTAG master running RESET / IR scan / DR scan / IDLE commands
//            while tracking the target TAP state cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_driver #(
    parameter int MAX_LEN = 32
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic [3:0]         state
);

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_IDLE  = 2'd3;

    localparam logic [3:0] ST_TLR    = 4'd15;
    localparam logic [3:0] ST_RTI    = 4'd12;
    localparam logic [3:0] ST_SEL_DR = 4'd7;
    localparam logic [3:0] ST_CAP_DR = 4'd6;
    localparam logic [3:0] ST_SH_DR  = 4'd2;
    localparam logic [3:0] ST_EX1_DR = 4'd1;
    localparam logic [3:0] ST_PA_DR  = 4'd3;
    localparam logic [3:0] ST_EX2_DR = 4'd0;
    localparam logic [3:0] ST_UPD_DR = 4'd5;
    localparam logic [3:0] ST_SEL_IR = 4'd4;
    localparam logic [3:0] ST_CAP_IR = 4'd14;
    localparam logic [3:0] ST_SH_IR  = 4'd10;
    localparam logic [3:0] ST_EX1_IR = 4'd9;
    localparam logic [3:0] ST_PA_IR  = 4'd11;
    localparam logic [3:0] ST_EX2_IR = 4'd8;
    localparam logic [3:0] ST_UPD_IR = 4'd13;

    // Step counter must reach MAX_LEN+6 and hold the raw 6-bit cmd_len.
    localparam int STEP_W = ($clog2(MAX_LEN + 8) > 7) ? $clog2(MAX_LEN + 8) : 7;
    localparam logic [STEP_W-1:0] C_MAX = STEP_W'(MAX_LEN);

    function automatic logic [3:0] tap_next(input logic [3:0] cs, input logic m);
        case (cs)
            ST_TLR:    tap_next = m ? ST_TLR    : ST_RTI;
            ST_RTI:    tap_next = m ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: tap_next = m ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: tap_next = m ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  tap_next = m ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: tap_next = m ? ST_UPD_DR : ST_PA_DR;
            ST_PA_DR:  tap_next = m ? ST_EX2_DR : ST_PA_DR;
            ST_EX2_DR: tap_next = m ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: tap_next = m ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: tap_next = m ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: tap_next = m ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  tap_next = m ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: tap_next = m ? ST_UPD_IR : ST_PA_IR;
            ST_PA_IR:  tap_next = m ? ST_EX2_IR : ST_PA_IR;
            ST_EX2_IR: tap_next = m ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: tap_next = m ? ST_SEL_DR : ST_RTI;
            default:   tap_next = ST_TLR;
        endcase
    endfunction

    logic [3:0]         state_q, state_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               busy_q, busy_d;
    logic [1:0]         op_q, op_d;
    logic [STEP_W-1:0]  n_q, n_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;

    logic [STEP_W-1:0]  len_ext, n_in, pre_len, shift_end, done_step;
    logic               is_scan, ready;

    always_comb begin
        len_ext   = {{(STEP_W-6){1'b0}}, cmd_len};
        n_in      = (len_ext == '0) ? STEP_W'(1) : ((len_ext > C_MAX) ? C_MAX : len_ext);
        is_scan   = (op_q == OP_DR) || (op_q == OP_IR);
        // pre_len = first step whose registered TMS is a shift edge
        pre_len   = (op_q == OP_IR) ? STEP_W'(4) : STEP_W'(3);
        shift_end = pre_len + n_q;
        case (op_q)
            OP_RESET: done_step = STEP_W'(6);
            OP_IDLE:  done_step = n_q;
            default:  done_step = shift_end + STEP_W'(2);
        endcase
        ready = (state_q == ST_RTI) && !busy_q;
    end

    always_comb begin
        state_d     = tap_next(state_q, tms_q);
        tms_d       = 1'b0;
        tdi_d       = 1'b0;
        busy_d      = busy_q;
        op_d        = op_q;
        n_d         = n_q;
        step_d      = step_q;
        data_d      = data_q;
        cap_d       = cap_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        if (busy_q) begin
            step_d = step_q + STEP_W'(1);
            if (step_q == done_step) begin
                busy_d      = 1'b0;
                rsp_valid_d = 1'b1;
                // captured bits arrive from the top; realign so bit 0 is the first one
                rsp_data_d  = cap_q >> (C_MAX - n_q);
            end else if (is_scan) begin
                tms_d = (step_q < (pre_len - STEP_W'(2))) ||
                        (step_q == (shift_end - STEP_W'(1))) ||
                        (step_q == shift_end);
                if ((step_q >= pre_len) && (step_q < shift_end)) begin
                    tdi_d  = data_q[0];
                    data_d = data_q >> 1;
                end
                if ((step_q > pre_len) && (step_q <= shift_end)) begin
                    cap_d = {tdo, cap_q[MAX_LEN-1:1]};
                end
            end else if (op_q == OP_RESET) begin
                tms_d = (step_q < STEP_W'(5));
            end
        end else if (cmd_valid && ready) begin
            busy_d = 1'b1;
            op_d   = cmd_op;
            n_d    = n_in;
            step_d = STEP_W'(1);
            data_d = cmd_data;
            cap_d  = '0;
            tms_d  = (cmd_op != OP_IDLE);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_TLR;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            busy_q      <= 1'b0;
            op_q        <= OP_RESET;
            n_q         <= '0;
            step_q      <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            busy_q      <= busy_d;
            op_q        <= op_d;
            n_q         <= n_d;
            step_q      <= step_d;
            data_q      <= data_d;
            cap_q       <= cap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_driver
// Purpose  : Randomised scoreboard bench for jtag_driver with a per-cycle
//            expected-trace queue built from the command TMS/state sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_driver;

    logic        CLK, RESET_N;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        tms, tdi, tdo;
    logic [3:0]  state;

    jtag_driver #(.MAX_LEN(32)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .tms(tms), .tdi(tdi), .tdo(tdo), .state(state)
    );

    typedef struct {
        logic [3:0] st;
        logic       tm;
        logic       ti;
        logic       to;
        logic       rdy;
        logic       vld;
    } cyc_t;

    cyc_t        q_cyc[$];
    logic [31:0] q_rsp[$];
    logic [31:0] last_rsp;
    bit          mon_en;
    int          n_cmp, n_err;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    task automatic add(input int s, input bit t, input bit ti, input bit to, input bit last);
        cyc_t r;
        r.st = 4'(s); r.tm = t; r.ti = ti; r.to = to; r.rdy = last; r.vld = last;
        q_cyc.push_back(r);
    endtask

    // Expected trace for cycles 0..T after the acceptance edge, straight from
    // the state/TMS sequence each command is defined by.
    task automatic push_cmd(input logic [1:0] op, input logic [5:0] len,
                            input logic [31:0] data, input logic [31:0] pat);
        int l, n, sh;
        logic [31:0] mask;
        l = int'(len);
        n = (l == 0) ? 1 : ((l > 32) ? 32 : l);
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        case (op)
            2'd0: begin
                add(12, 1, 0, rb(), 0); add(7, 1, 0, rb(), 0); add(4, 1, 0, rb(), 0);
                add(15, 1, 0, rb(), 0); add(15, 1, 0, rb(), 0); add(15, 0, 0, rb(), 0);
                add(12, 0, 0, rb(), 1);
                q_rsp.push_back(32'h0);
            end
            2'd3: begin
                for (int i = 0; i <= n; i++) add(12, 0, 0, rb(), i == n);
                q_rsp.push_back(32'h0);
            end
            default: begin
                sh = (op == 2'd2) ? 2 : 10;
                if (op == 2'd2) begin
                    add(12, 1, 0, rb(), 0); add(7, 0, 0, rb(), 0); add(6, 0, 0, rb(), 0);
                end else begin
                    add(12, 1, 0, rb(), 0); add(7, 1, 0, rb(), 0);
                    add(4, 0, 0, rb(), 0);  add(14, 0, 0, rb(), 0);
                end
                for (int i = 0; i < n; i++)
                    add(sh, i == n - 1, 1'(data >> i), 1'(pat >> i), 0);
                add((op == 2'd2) ? 1 : 9, 1, 0, rb(), 0);
                add((op == 2'd2) ? 5 : 13, 0, 0, rb(), 0);
                add(12, 0, 0, rb(), 1);
                q_rsp.push_back(pat & mask);
            end
        endcase
    endtask

    // Monitor: compare every cycle against the trace, drive tdo, score responses.
    initial begin
        cyc_t r;
        logic [31:0] e;
        tdo = 1'b0;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (q_cyc.size() > 0) begin
                    r = q_cyc.pop_front();
                    chk("state", 32'(state), 32'(r.st));
                    chk("tms", 32'(tms), 32'(r.tm));
                    chk("tdi", 32'(tdi), 32'(r.ti));
                    chk("cmd_ready", 32'(cmd_ready), 32'(r.rdy));
                    chk("rsp_valid", 32'(rsp_valid), 32'(r.vld));
                    tdo = r.to;
                end else begin
                    chk("idle_state", 32'(state), 32'd12);
                    chk("idle_tms", 32'(tms), 32'd0);
                    chk("idle_tdi", 32'(tdi), 32'd0);
                    chk("idle_ready", 32'(cmd_ready), 32'd1);
                    tdo = rb();
                end
                if (rsp_valid === 1'b1) begin
                    if (q_rsp.size() > 0) begin
                        e = q_rsp.pop_front();
                        chk("rsp_data", rsp_data, e);
                        last_rsp = e;
                    end else begin
                        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                    end
                end else begin
                    chk("rsp_hold", rsp_data, last_rsp);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] len,
                         input logic [31:0] data, input logic [31:0] pat);
        int w;
        bit done;
        w = 0;
        done = 0;
        while (!done) begin
            @(negedge CLK);
            #2;
            cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
            if (cmd_ready) begin
                push_cmd(op, len, data, pat);
                @(posedge CLK);
                done = 1;
            end else if (++w > 200) begin
                chk("ready_timeout", 32'(cmd_ready), 32'd1);
                cmd_valid = 1'b0;
                done = 1;
            end
        end
    endtask

    task automatic gap(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge CLK);
            #2;
            cmd_valid = 1'b0;
            cmd_op    = 2'($urandom);
            cmd_data  = $urandom;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd15);
        chk({tag, "_tms"}, 32'(tms), 32'd1);
        chk({tag, "_tdi"}, 32'(tdi), 32'd0);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    endtask

    task automatic boot();
        @(negedge CLK);
        chk("boot_state_first", 32'(state), 32'd15);
        chk("boot_ready_first", 32'(cmd_ready), 32'd0);
        @(negedge CLK);
        chk("boot_state_next", 32'(state), 32'd12);
        chk("boot_ready_next", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; mon_en = 0; last_rsp = 32'h0;
        RESET_N = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 6'd0; cmd_data = 32'h0;
        repeat (3) @(negedge CLK);
        check_reset("por");
        #2 RESET_N = 1'b1;
        boot();
        mon_en = 1;

        issue(2'd2, 6'd8, 32'h0000_00A5, 32'h0000_003C); gap(2);
        issue(2'd1, 6'd4, 32'h0000_0009, $urandom);      gap(1);
        issue(2'd0, 6'($urandom), $urandom, $urandom);   gap(1);
        issue(2'd2, 6'd0, $urandom, $urandom);           gap(1);
        issue(2'd2, 6'd40, $urandom, $urandom);          gap(1);
        issue(2'd3, 6'd3, $urandom, $urandom);           gap(1);
        issue(2'd2, 6'd5, $urandom, $urandom);
        issue(2'd2, 6'd7, $urandom, $urandom);           gap(1);

        for (int c = 0; c < 40; c++) begin
            issue(2'($urandom_range(0, 3)), 6'($urandom_range(0, 40)), $urandom, $urandom);
            if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
        end

        issue(2'd2, 6'd16, $urandom, $urandom);
        gap(7);
        mon_en = 0;
        RESET_N = 1'b0;
        #1;
        check_reset("midrst");
        q_cyc.delete();
        q_rsp.delete();
        last_rsp = 32'h0;
        repeat (4) begin
            @(negedge CLK);
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("midrst_state", 32'(state), 32'd15);
        end
        #2 RESET_N = 1'b1;
        boot();
        mon_en = 1;

        issue(2'd2, 6'd12, $urandom, $urandom);
        issue(2'd3, 6'd2, $urandom, $urandom);
        gap(1);

        for (int k = 0; k < 100 && q_cyc.size() > 0; k++) @(negedge CLK);
        repeat (2) @(negedge CLK);
        chk("rsp_outstanding", 32'(q_rsp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
